// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces it and emits one event pulse per press
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [4:0] value
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, CONFIRM, EMIT, HELD} state_e;

    state_e          state_q;
    logic [3:0]      rows_meta_q, rows_sync_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [1:0]      col_q;
    logic [3:0]      columns_q;
    logic [4:0]      value_q;
    logic [3:0]      cand_q;
    logic [CW-1:0]   press_q, press_d, rel_q, rel_d;
    logic            sample, any_low, cand_low;
    logic [1:0]      row_sel;

    assign columns = columns_q;
    assign value   = value_q;

    // Sample-point detection, lowest-row priority and saturating debounce increments
    always_comb begin
        sample   = dwell_q == DWELL_LAST;
        dwell_d  = sample ? '0 : dwell_q + 1'b1;
        any_low  = ~&rows_sync_q;
        row_sel  = !rows_sync_q[0] ? 2'd0 : !rows_sync_q[1] ? 2'd1 : !rows_sync_q[2] ? 2'd2 : 2'd3;
        cand_low = !rows_sync_q[cand_q[1:0]];
        press_d  = (press_q == DB_LAST) ? press_q : press_q + 1'b1;
        rel_d    = (rel_q == DB_LAST) ? rel_q : rel_q + 1'b1;
    end

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= 4'hF;
            rows_sync_q <= 4'hF;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Free-running column dwell counter; its last count is the sample point
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dwell_q <= '0;
        else        dwell_q <= dwell_d;
    end

    // Scan / confirm / emit / held-until-release state machine with registered column drive and event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            columns_q <= 4'b1110;
            value_q   <= 5'd0;
            cand_q    <= 4'd0;
            press_q   <= '0;
            rel_q     <= '0;
        end else begin
            value_q <= 5'd0;
            case (state_q)
                SCAN: if (sample) begin
                    if (any_low) begin
                        cand_q  <= {col_q, row_sel};
                        press_q <= CW'(1);
                        state_q <= (DEBOUNCE_SCANS == 1) ? EMIT : CONFIRM;
                    end else begin
                        col_q     <= col_q + 1'b1;
                        columns_q <= {columns_q[2:0], columns_q[3]};
                    end
                end
                CONFIRM: if (sample) begin
                    if (cand_low) begin
                        press_q <= press_d;
                        if (press_d == DB_LAST) state_q <= EMIT;
                    end else begin
                        press_q   <= '0;
                        state_q   <= SCAN;
                        col_q     <= col_q + 1'b1;
                        columns_q <= {columns_q[2:0], columns_q[3]};
                    end
                end
                EMIT: begin
                    value_q <= {1'b1, cand_q};
                    rel_q   <= '0;
                    state_q <= HELD;
                end
                HELD: if (sample) begin
                    if (!cand_low) begin
                        rel_q <= rel_d;
                        if (rel_d == DB_LAST) begin
                            state_q   <= SCAN;
                            col_q     <= col_q + 1'b1;
                            columns_q <= {columns_q[2:0], columns_q[3]};
                        end
                    end else begin
                        rel_q <= '0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end
endmodule
